// File: rtl/i8048_trace_pkg.sv
// Shared types for the 8048 PC trace buffer: FSM states, entry layout, capture modes.
package i8048_trace_pkg;

    localparam int unsigned DefPcW   = 12;
    localparam int unsigned DefTsW   = 24;
    localparam int unsigned DefRepW  = 8;
    localparam int unsigned DefDepth = 64;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StArmed   = 3'd1,
        StCapture = 3'd2,
        StPost    = 3'd3,
        StDone    = 3'd4
    } trace_state_e;

    // One stored PC run, packed as {ts, pc, rep} to match rd_data.
    typedef struct packed {
        logic [DefTsW-1:0]  ts;
        logic [DefPcW-1:0]  pc;
        logic [DefRepW-1:0] rep;
    } trace_entry_t;

    localparam logic ModeStart = 1'b0;
    localparam logic ModeWrap  = 1'b1;

endpackage

// File: rtl/i8048_trace_ram.sv
// Single-clock register array, one write port and one read port with registered read data.
module i8048_trace_ram
    import i8048_trace_pkg::*;
#(
    parameter int unsigned Depth = DefDepth,
    parameter int unsigned Width = DefTsW + DefPcW + DefRepW,
    localparam int unsigned Aw = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [Aw-1:0]    waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [Aw-1:0]    raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [Depth];

    // Write port and registered read; a same-address read returns the old contents.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule

// File: rtl/i8048_pc_trace_buf.sv
// PC trace capture: run-length encodes the core PC into {ts, pc, rep} entries held in a
// circular buffer, with trigger-on-PC, START/WRAP windows and an oldest-first readout port.
module i8048_pc_trace_buf
    import i8048_trace_pkg::*;
#(
    parameter int unsigned PC_W  = DefPcW,
    parameter int unsigned TS_W  = DefTsW,
    parameter int unsigned REP_W = DefRepW,
    parameter int unsigned DEPTH = DefDepth,
    localparam int unsigned AW = $clog2(DEPTH),
    localparam int unsigned CW = AW + 1,
    localparam int unsigned EW = TS_W + PC_W + REP_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PC_W-1:0] pc_i,
    input  logic            pc_valid,
    input  logic            arm,
    input  logic            stop,
    input  logic            mode,
    input  logic [PC_W-1:0] trig_pc,
    input  logic [CW-1:0]   post_cnt,
    output logic            rd_valid,
    input  logic            rd_ready,
    output logic [EW-1:0]   rd_data,
    output logic [2:0]      state_o,
    output logic [CW-1:0]   count_o,
    output logic            triggered,
    output logic            overflow
);

    localparam logic [CW-1:0] FullCnt = CW'(DEPTH);
    localparam logic [CW-1:0] LastCnt = CW'(DEPTH - 1);

    trace_state_e st_q, st_d;
    logic [TS_W-1:0]  ts_q;
    logic             mode_q, mode_d;
    logic [PC_W-1:0]  trig_q, trig_d;
    logic [CW-1:0]    post_cfg_q, post_cfg_d;
    logic [CW-1:0]    post_left_q, post_left_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             trig_seen_q, trig_seen_d;
    logic             ovf_q, ovf_d;
    logic [TS_W-1:0]  stg_ts_q, stg_ts_d;
    logic [PC_W-1:0]  stg_pc_q, stg_pc_d;
    logic [REP_W-1:0] stg_rep_q, stg_rep_d;
    logic             stg_v_q, stg_v_d;
    logic             rd_valid_q, rd_valid_d;

    logic             sample;
    logic             ram_we;
    logic [EW-1:0]    ram_rdata;

    // Next-state: arm overrides everything, stop beats a same-cycle sample, pops only in DONE.
    always_comb begin
        st_d        = st_q;
        mode_d      = mode_q;
        trig_d      = trig_q;
        post_cfg_d  = post_cfg_q;
        post_left_d = post_left_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        trig_seen_d = trig_seen_q;
        ovf_d       = ovf_q;
        stg_ts_d    = stg_ts_q;
        stg_pc_d    = stg_pc_q;
        stg_rep_d   = stg_rep_q;
        stg_v_d     = stg_v_q;
        sample      = 1'b0;
        ram_we      = 1'b0;

        if (arm) begin
            st_d        = (mode == ModeWrap) ? StCapture : StArmed;
            mode_d      = mode;
            trig_d      = trig_pc;
            post_cfg_d  = post_cnt;
            post_left_d = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            trig_seen_d = 1'b0;
            ovf_d       = 1'b0;
            stg_v_d     = 1'b0;
        end else begin
            unique case (st_q)
                StIdle: ;
                StArmed: begin
                    if (stop) begin
                        st_d = StDone;
                    end else if (pc_valid && pc_i == trig_q) begin
                        // START trigger: this sample opens the first run.
                        trig_seen_d = 1'b1;
                        st_d        = StCapture;
                        sample      = 1'b1;
                    end
                end
                StCapture, StPost: begin
                    if (stop) begin
                        st_d = StDone;
                    end else if (pc_valid) begin
                        sample = 1'b1;
                    end
                end
                StDone: begin
                    if (rd_valid_q && rd_ready) begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                        count_d  = count_q - CW'(1);
                    end
                end
                default: st_d = StIdle;
            endcase

            if (sample) begin
                if (!stg_v_q) begin
                    stg_ts_d  = ts_q;
                    stg_pc_d  = pc_i;
                    stg_rep_d = REP_W'(1);
                    stg_v_d   = 1'b1;
                end else if (pc_i == stg_pc_q) begin
                    if (stg_rep_q != '1) begin
                        stg_rep_d = stg_rep_q + REP_W'(1);
                    end
                end else begin
                    // Run ended: commit the staged entry and open a new run.
                    ram_we    = 1'b1;
                    stg_ts_d  = ts_q;
                    stg_pc_d  = pc_i;
                    stg_rep_d = REP_W'(1);
                    wr_ptr_d  = wr_ptr_q + AW'(1);
                    if (count_q == FullCnt) begin
                        rd_ptr_d = rd_ptr_q + AW'(1);
                        ovf_d    = 1'b1;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                    if (mode_q == ModeStart && count_q == LastCnt) begin
                        st_d = StDone;
                    end
                    if (st_q == StPost) begin
                        post_left_d = post_left_q - CW'(1);
                        if (post_left_q == CW'(1)) begin
                            st_d = StDone;
                        end
                    end
                end

                if (st_q == StCapture && mode_q == ModeWrap && pc_i == trig_q) begin
                    trig_seen_d = 1'b1;
                    post_left_d = post_cfg_q;
                    st_d        = (post_cfg_q == '0) ? StDone : StPost;
                end
            end
        end

        // The open run is never flushed into the buffer once capture ends.
        if (st_d == StDone) begin
            stg_v_d = 1'b0;
        end

        rd_valid_d = (st_q == StDone) && (st_d == StDone) && (count_d != '0);
    end

    // State, pointer, stage and timestamp registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q        <= StIdle;
            ts_q        <= '0;
            mode_q      <= ModeStart;
            trig_q      <= '0;
            post_cfg_q  <= '0;
            post_left_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            trig_seen_q <= 1'b0;
            ovf_q       <= 1'b0;
            stg_ts_q    <= '0;
            stg_pc_q    <= '0;
            stg_rep_q   <= '0;
            stg_v_q     <= 1'b0;
            rd_valid_q  <= 1'b0;
        end else begin
            st_q        <= st_d;
            ts_q        <= ts_q + TS_W'(1);
            mode_q      <= mode_d;
            trig_q      <= trig_d;
            post_cfg_q  <= post_cfg_d;
            post_left_q <= post_left_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            trig_seen_q <= trig_seen_d;
            ovf_q       <= ovf_d;
            stg_ts_q    <= stg_ts_d;
            stg_pc_q    <= stg_pc_d;
            stg_rep_q   <= stg_rep_d;
            stg_v_q     <= stg_v_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    // Read address follows the next read pointer so ram_rdata always shows the current head.
    i8048_trace_ram #(
        .Depth (DEPTH),
        .Width (EW)
    ) u_ram (
        .clk_i   (clk),
        .we_i    (ram_we),
        .waddr_i (wr_ptr_q),
        .wdata_i ({stg_ts_q, stg_pc_q, stg_rep_q}),
        .raddr_i (rd_ptr_d),
        .rdata_o (ram_rdata)
    );

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_valid_q ? ram_rdata : '0;
    assign state_o   = st_q;
    assign count_o   = count_q;
    assign triggered = trig_seen_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_i8048_pc_trace_buf.sv
// Scoreboard bench for the PC trace buffer: a run-length model pushes expected entries as
// PCs are driven, and the readout port pops and compares them.
module tb_i8048_pc_trace_buf;
    import i8048_trace_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 3;
    localparam int unsigned EW    = DefTsW + DefPcW + DefRepW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [11:0]     pc_i = '0;
    logic            pc_valid = 1'b0;
    logic            arm = 1'b0;
    logic            stop = 1'b0;
    logic            mode = 1'b0;
    logic [11:0]     trig_pc = '0;
    logic [CW-1:0]   post_cnt = '0;
    logic            rd_valid;
    logic            rd_ready = 1'b0;
    logic [EW-1:0]   rd_data;
    logic [2:0]      state_o;
    logic [CW-1:0]   count_o;
    logic            triggered;
    logic            overflow;

    int n_checks = 0;
    int n_fail   = 0;

    logic [23:0]  model_ts = '0;
    trace_entry_t exp_q[$];
    trace_entry_t m_stg;
    logic         m_v = 1'b0;

    i8048_pc_trace_buf #(
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_i      (pc_i),
        .pc_valid  (pc_valid),
        .arm       (arm),
        .stop      (stop),
        .mode      (mode),
        .trig_pc   (trig_pc),
        .post_cnt  (post_cnt),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .state_o   (state_o),
        .count_o   (count_o),
        .triggered (triggered),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference cycle counter: free-running, cleared by reset.
    always @(posedge clk) begin
        if (rst) model_ts <= '0;
        else     model_ts <= model_ts + 24'd1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "bench timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_sample(input logic [11:0] pc);
        if (!m_v) begin
            m_stg.ts = model_ts; m_stg.pc = pc; m_stg.rep = 8'd1; m_v = 1'b1;
        end else if (pc == m_stg.pc) begin
            if (m_stg.rep != 8'hFF) m_stg.rep = m_stg.rep + 8'd1;
        end else begin
            exp_q.push_back(m_stg);
            if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
            m_stg.ts = model_ts; m_stg.pc = pc; m_stg.rep = 8'd1;
        end
    endtask

    task automatic send(input logic [11:0] pc, input bit captured);
        pc_i = pc;
        pc_valid = 1'b1;
        if (captured) model_sample(pc);
        tick();
        pc_valid = 1'b0;
    endtask

    task automatic do_arm(input logic m, input logic [11:0] trig, input logic [CW-1:0] post);
        arm = 1'b1; mode = m; trig_pc = trig; post_cnt = post;
        tick();
        arm = 1'b0;
        exp_q.delete();
        m_v = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        m_v = 1'b0;
    endtask

    // Pops everything; with toggle set, rd_ready follows 1,0,0,1 and stalled data must hold.
    task automatic drain(input string tag, input bit toggle);
        int guard = 0;
        int k = 0;
        bit stalled = 1'b0;
        logic [EW-1:0] held = '0;
        trace_entry_t e;
        while (!rd_valid && guard < 8) begin tick(); guard++; end
        while (rd_valid && guard < 64) begin
            if (stalled) check_eq({tag, " hold"}, rd_data, held);
            if (!toggle || (k % 4 == 0) || (k % 4 == 3)) begin
                rd_ready = 1'b1;
                if (exp_q.size() == 0) begin
                    check_eq({tag, " extra"}, rd_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq({tag, " entry"}, rd_data, e);
                end
                stalled = 1'b0;
            end else begin
                rd_ready = 1'b0;
                held = rd_data;
                stalled = 1'b1;
            end
            tick();
            k++;
            guard++;
        end
        rd_ready = 1'b0;
        check_eq({tag, " drained"}, exp_q.size(), 0);
        check_eq({tag, " count end"}, count_o, 0);
        check_eq({tag, " valid end"}, rd_valid, 1'b0);
    endtask

    initial begin
        // Reset values
        tick(); tick();
        check_eq("rst state", state_o, StIdle);
        check_eq("rst count", count_o, 0);
        check_eq("rst valid", rd_valid, 1'b0);
        check_eq("rst data", rd_data, 0);
        check_eq("rst trig", triggered, 1'b0);
        check_eq("rst ovf", overflow, 1'b0);
        rst = 1'b0;
        tick();

        // START mode with run-length compression
        do_arm(ModeStart, 12'h010, '0);
        check_eq("t1 armed", state_o, StArmed);
        send(12'h00E, 1'b0);
        send(12'h00F, 1'b0);
        check_eq("t1 still armed", state_o, StArmed);
        send(12'h010, 1'b1);
        check_eq("t1 capture", state_o, StCapture);
        check_eq("t1 triggered", triggered, 1'b1);
        send(12'h011, 1'b1);
        send(12'h011, 1'b1);
        send(12'h011, 1'b1);
        send(12'h012, 1'b1);
        send(12'h013, 1'b1);
        check_eq("t1 count", count_o, 3);
        do_stop();
        check_eq("t1 done", state_o, StDone);
        drain("t1", 1'b0);

        // START mode fills the buffer
        do_arm(ModeStart, 12'h100, '0);
        for (int i = 0; i < 5; i++) send(12'h100 + 12'(i), 1'b1);
        m_v = 1'b0;
        check_eq("t2 done", state_o, StDone);
        check_eq("t2 count", count_o, 4);
        check_eq("t2 ovf", overflow, 1'b0);
        check_eq("t2 valid lag", rd_valid, 1'b0);
        tick();
        check_eq("t2 valid rise", rd_valid, 1'b1);
        drain("t2", 1'b0);

        // WRAP mode, post-trigger window, stalling readout
        do_arm(ModeWrap, 12'h207, 3'd2);
        check_eq("t3 capture", state_o, StCapture);
        for (int i = 0; i < 8; i++) send(12'h200 + 12'(i), 1'b1);
        check_eq("t3 post", state_o, StPost);
        send(12'h208, 1'b1);
        check_eq("t3 still post", state_o, StPost);
        send(12'h209, 1'b1);
        m_v = 1'b0;
        check_eq("t3 done", state_o, StDone);
        check_eq("t3 ovf", overflow, 1'b1);
        check_eq("t3 trig", triggered, 1'b1);
        check_eq("t3 count", count_o, 4);
        drain("t3", 1'b1);

        // Repeat count saturation
        do_arm(ModeStart, 12'h300, '0);
        for (int i = 0; i < 300; i++) send(12'h300, 1'b1);
        send(12'h301, 1'b1);
        check_eq("t4 count", count_o, 1);
        do_stop();
        drain("t4", 1'b0);

        // Reset mid-capture
        do_arm(ModeWrap, 12'hFFF, 3'd1);
        for (int i = 0; i < 4; i++) send(12'h400 + 12'(i), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("t5 state", state_o, StIdle);
        check_eq("t5 count", count_o, 0);
        check_eq("t5 valid", rd_valid, 1'b0);
        check_eq("t5 ovf", overflow, 1'b0);
        check_eq("t5 trig", triggered, 1'b0);

        // Arm during readout discards the rest
        do_arm(ModeStart, 12'h500, '0);
        for (int i = 0; i < 4; i++) send(12'h500 + 12'(i), 1'b1);
        do_stop();
        tick();
        check_eq("t6 valid", rd_valid, 1'b1);
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
        arm = 1'b1; mode = ModeStart; trig_pc = 12'h600;
        tick();
        arm = 1'b0;
        exp_q.delete();
        check_eq("t6 state", state_o, StArmed);
        check_eq("t6 count", count_o, 0);
        check_eq("t6 valid", rd_valid, 1'b0);
        check_eq("t6 data", rd_data, 0);
        check_eq("t6 trig", triggered, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
